// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-session arbiter.
package vend_pkg;

    localparam int NUM_PANELS = 2;
    localparam int CREDIT_W   = 3;

    localparam logic [CREDIT_W-1:0] CREDIT_ONE  = 3'd2;
    localparam logic [CREDIT_W-1:0] CREDIT_HALF = 3'd1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SESSION,
        ST_DONE,
        ST_ABORT
    } state_t;

    function automatic int timer_width(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc + 1);
    endfunction

    // OneTL wins over HalfTL in the same cycle, mirroring the core's priority.
    function automatic logic [CREDIT_W-1:0] credit_add(input logic [CREDIT_W-1:0] credit,
                                                       input logic one,
                                                       input logic half);
        logic [CREDIT_W:0] sum;
        sum = {1'b0, credit};
        if (one)
            sum = sum + {1'b0, CREDIT_ONE};
        else if (half)
            sum = sum + {1'b0, CREDIT_HALF};
        return (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[CREDIT_W-1:0];
    endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Two-way round-robin pick; the requester that did not own the last session wins a tie.
module vend_rr_arbiter (
    input  logic [1:0] Req,
    input  logic       Last,
    output logic [1:0] Grant
);

    always_comb begin
        // NOTE: default assignment first so every path drives Grant and no latch is inferred.
        Grant = Req;
        if (Req == 2'b11)
            Grant = Last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/vend_session_arbiter.sv
// Shares one VendingMachine core between two panels with exclusive, cleared sessions.
// Optional inactivity timeout is compiled in with `define VEND_ARB_TIMEOUT_EN.
module vend_session_arbiter
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] Pnl_Req,
    input  logic [1:0] Pnl_OneTL,
    input  logic [1:0] Pnl_HalfTL,
    input  logic [1:0] Pnl_Coke,
    input  logic [1:0] Pnl_Water,
    output logic [1:0] Pnl_Grant,
    output logic [1:0] Pnl_Done,
    output logic [1:0] Pnl_Abort,
    output logic [2:0] Refund_Amt,
    output logic       Vm_Req,
    output logic       Vm_OneTL,
    output logic       Vm_HalfTL,
    output logic       Vm_Coke,
    output logic       Vm_Water,
    input  logic       Vm_G_Coke,
    input  logic       Vm_G_Water,
    input  logic       Vm_Change1,
    input  logic       Vm_Change05
);

    state_t              state;
    logic                owner;
    logic                last;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_next;
    logic [1:0]          rr_grant;
    logic                own_one, own_half, own_coke, own_water, own_any;
    logic                timed_out;
    logic                unused_change;

    assign unused_change = Vm_Change1 ^ Vm_Change05;

    vend_rr_arbiter u_rr (
        .Req   (Pnl_Req),
        .Last  (last),
        .Grant (rr_grant)
    );

    assign own_one     = Pnl_OneTL[owner];
    assign own_half    = Pnl_HalfTL[owner];
    assign own_coke    = Pnl_Coke[owner];
    assign own_water   = Pnl_Water[owner];
    assign own_any     = own_one | own_half | own_coke | own_water;
    assign credit_next = credit_add(credit, own_one, own_half);

`ifdef VEND_ARB_TIMEOUT_EN
    localparam int             TMR_W   = timer_width(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

    logic [TMR_W-1:0] timer;

    assign timed_out = (timer == TMR_MAX);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            timer <= '0;
        else if (state == ST_CLEAR || (state == ST_SESSION && own_any))
            timer <= '0;
        else if (state == ST_SESSION && !timed_out)
            timer <= timer + 1'b1;
    end
`else
    logic unused_timeout_cfg;

    assign timed_out          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            credit     <= '0;
            Pnl_Grant  <= '0;
            Pnl_Done   <= '0;
            Pnl_Abort  <= '0;
            Refund_Amt <= '0;
            Vm_Req     <= 1'b0;
            Vm_OneTL   <= 1'b0;
            Vm_HalfTL  <= 1'b0;
            Vm_Coke    <= 1'b0;
            Vm_Water   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every register sees pre-edge values of the others.
            Pnl_Done   <= '0;
            Pnl_Abort  <= '0;
            Refund_Amt <= '0;
            Vm_Req     <= 1'b0;
            Vm_OneTL   <= 1'b0;
            Vm_HalfTL  <= 1'b0;
            Vm_Coke    <= 1'b0;
            Vm_Water   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|Pnl_Req) begin
                        owner     <= rr_grant[1];
                        Pnl_Grant <= rr_grant;
                        Vm_Req    <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    credit <= '0;
                    state  <= ST_SESSION;
                end
                ST_SESSION: begin
                    Vm_OneTL  <= own_one;
                    Vm_HalfTL <= own_half;
                    Vm_Coke   <= own_coke;
                    Vm_Water  <= own_water;
                    credit    <= credit_next;
                    // Dispense outranks withdrawal, which outranks timeout.
                    if (Vm_G_Coke || Vm_G_Water) begin
                        Pnl_Done <= Pnl_Grant;
                        Vm_Req   <= 1'b1;
                        state    <= ST_DONE;
                    end else if (!Pnl_Req[owner] || timed_out) begin
                        Pnl_Abort  <= Pnl_Grant;
                        Refund_Amt <= credit_next;
                        Vm_Req     <= 1'b1;
                        state      <= ST_ABORT;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    last      <= owner;
                    Pnl_Grant <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed self-checking bench for vend_session_arbiter; timeout section follows VEND_ARB_TIMEOUT_EN.
module tb_vend_session_arbiter;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [1:0] Pnl_Req, Pnl_OneTL, Pnl_HalfTL, Pnl_Coke, Pnl_Water;
    logic [1:0] Pnl_Grant, Pnl_Done, Pnl_Abort;
    logic [2:0] Refund_Amt;
    logic       Vm_Req, Vm_OneTL, Vm_HalfTL, Vm_Coke, Vm_Water;
    logic       Vm_G_Coke, Vm_G_Water, Vm_Change1, Vm_Change05;

    int checks = 0;
    int errors = 0;

    vend_session_arbiter #(.TIMEOUT_CYC(8)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Pnl_Req     (Pnl_Req),
        .Pnl_OneTL   (Pnl_OneTL),
        .Pnl_HalfTL  (Pnl_HalfTL),
        .Pnl_Coke    (Pnl_Coke),
        .Pnl_Water   (Pnl_Water),
        .Pnl_Grant   (Pnl_Grant),
        .Pnl_Done    (Pnl_Done),
        .Pnl_Abort   (Pnl_Abort),
        .Refund_Amt  (Refund_Amt),
        .Vm_Req      (Vm_Req),
        .Vm_OneTL    (Vm_OneTL),
        .Vm_HalfTL   (Vm_HalfTL),
        .Vm_Coke     (Vm_Coke),
        .Vm_Water    (Vm_Water),
        .Vm_G_Coke   (Vm_G_Coke),
        .Vm_G_Water  (Vm_G_Water),
        .Vm_Change1  (Vm_Change1),
        .Vm_Change05 (Vm_Change05)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic pulse(input logic [1:0] one, input logic [1:0] half,
                         input logic [1:0] coke, input logic [1:0] water);
        Pnl_OneTL  = one;
        Pnl_HalfTL = half;
        Pnl_Coke   = coke;
        Pnl_Water  = water;
        step();
        Pnl_OneTL  = 2'b00;
        Pnl_HalfTL = 2'b00;
        Pnl_Coke   = 2'b00;
        Pnl_Water  = 2'b00;
    endtask

    // From IDLE with Pnl_Req already set: CLEAR, then into SESSION.
    task automatic open_session(input logic [1:0] exp_grant, input string tag);
        step();
        check({tag, "_clear_grant"}, 8'(Pnl_Grant), 8'(exp_grant));
        check({tag, "_clear_vmreq"}, 8'(Vm_Req), 8'd1);
        step();
        check({tag, "_sess_vmreq"}, 8'(Vm_Req), 8'd0);
    endtask

    initial begin
        int waits;
        int abort_seen;

        Rst_n = 1'b0;
        Pnl_Req = 2'b00; Pnl_OneTL = 2'b00; Pnl_HalfTL = 2'b00;
        Pnl_Coke = 2'b00; Pnl_Water = 2'b00;
        Vm_G_Coke = 1'b0; Vm_G_Water = 1'b0; Vm_Change1 = 1'b0; Vm_Change05 = 1'b0;
        step();
        step();
        check("rst_grant",  8'(Pnl_Grant),  8'd0);
        check("rst_vmreq",  8'(Vm_Req),     8'd0);
        check("rst_done",   8'(Pnl_Done),   8'd0);
        check("rst_abort",  8'(Pnl_Abort),  8'd0);
        check("rst_refund", 8'(Refund_Amt), 8'd0);
        Rst_n = 1'b1;
        step();
        check("idle_grant", 8'(Pnl_Grant), 8'd0);

        // Tie goes to panel 0 first; forwarding and dispense.
        Pnl_Req = 2'b11;
        open_session(2'b01, "s1");
        pulse(2'b01, 2'b00, 2'b00, 2'b00);
        check("fwd_one",   8'(Vm_OneTL),  8'd1);
        pulse(2'b00, 2'b01, 2'b00, 2'b00);
        check("fwd_half",  8'(Vm_HalfTL), 8'd1);
        check("fwd_one_0", 8'(Vm_OneTL),  8'd0);
        pulse(2'b00, 2'b00, 2'b00, 2'b01);
        check("fwd_water", 8'(Vm_Water),  8'd1);
        check("sess_refund0", 8'(Refund_Amt), 8'd0);
        Vm_G_Water = 1'b1;
        step();
        Vm_G_Water = 1'b0;
        check("done_pulse", 8'(Pnl_Done),  8'd1);
        check("done_vmreq", 8'(Vm_Req),    8'd1);
        check("done_grant", 8'(Pnl_Grant), 8'd1);
        check("done_abort", 8'(Pnl_Abort), 8'd0);
        step();
        check("idle2_grant", 8'(Pnl_Grant), 8'd0);
        check("idle2_done",  8'(Pnl_Done),  8'd0);

        // Round robin hands panel 1 the next session; a pulse in CLEAR is dropped.
        step();
        check("rr_grant", 8'(Pnl_Grant), 8'd2);
        check("rr_vmreq", 8'(Vm_Req),    8'd1);
        pulse(2'b10, 2'b00, 2'b00, 2'b00);
        check("clear_drop", 8'(Vm_OneTL), 8'd0);
        Pnl_Req = 2'b01;
        step();
        check("p1_abort",  8'(Pnl_Abort),  8'd2);
        check("p1_refund", 8'(Refund_Amt), 8'd0);
        step();
        check("idle3_grant", 8'(Pnl_Grant), 8'd0);

        // Withdrawal refund 2+2+1; panel 1 pulses are ignored.
        open_session(2'b01, "s3");
        pulse(2'b01, 2'b00, 2'b00, 2'b00);
        pulse(2'b10, 2'b00, 2'b00, 2'b00);
        check("nonowner_drop", 8'(Vm_OneTL), 8'd0);
        pulse(2'b01, 2'b00, 2'b00, 2'b00);
        pulse(2'b00, 2'b01, 2'b00, 2'b00);
        Pnl_Req = 2'b00;
        step();
        check("wd_abort",  8'(Pnl_Abort),  8'd1);
        check("wd_refund", 8'(Refund_Amt), 8'd5);
        check("wd_vmreq",  8'(Vm_Req),     8'd1);
        check("wd_grant",  8'(Pnl_Grant),  8'd1);
        step();
        check("wd_refund_clr", 8'(Refund_Amt), 8'd0);

        // OneTL and HalfTL together count only as OneTL.
        Pnl_Req = 2'b01;
        open_session(2'b01, "s4");
        pulse(2'b01, 2'b01, 2'b00, 2'b00);
        Pnl_Req = 2'b00;
        step();
        check("both_refund", 8'(Refund_Amt), 8'd2);
        step();

        // Saturation at 6.
        Pnl_Req = 2'b01;
        open_session(2'b01, "s5");
        for (int i = 0; i < 4; i++)
            pulse(2'b01, 2'b00, 2'b00, 2'b00);
        Pnl_Req = 2'b00;
        step();
        check("sat_refund", 8'(Refund_Amt), 8'd6);
        step();

        // Dispense and withdrawal in the same cycle: dispense wins.
        Pnl_Req = 2'b01;
        open_session(2'b01, "s6");
        Vm_G_Coke = 1'b1;
        Pnl_Req = 2'b00;
        step();
        Vm_G_Coke = 1'b0;
        check("prio_done",  8'(Pnl_Done),  8'd1);
        check("prio_abort", 8'(Pnl_Abort), 8'd0);
        step();

        // Inactivity timeout.
        Pnl_Req = 2'b01;
        open_session(2'b01, "s7");
        pulse(2'b00, 2'b01, 2'b00, 2'b00);
`ifdef VEND_ARB_TIMEOUT_EN
        waits = 0;
        while (waits < 20 && Pnl_Abort == 2'b00) begin
            step();
            waits++;
        end
        check("to_abort",  8'(Pnl_Abort),  8'd1);
        check("to_cycles", 8'(waits),      8'd9);
        check("to_refund", 8'(Refund_Amt), 8'd1);
        step();
`else
        abort_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (Pnl_Abort != 2'b00)
                abort_seen++;
        end
        check("no_timeout", 8'(abort_seen), 8'd0);
        Pnl_Req = 2'b00;
        step();
        check("late_abort",  8'(Pnl_Abort),  8'd1);
        check("late_refund", 8'(Refund_Amt), 8'd1);
        step();
`endif

        // Reset mid-session restores tie preference for panel 0.
        Pnl_Req = 2'b10;
        open_session(2'b10, "s8");
        Rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 8'(Pnl_Grant), 8'd0);
        check("mid_rst_vmreq", 8'(Vm_Req),    8'd0);
        step();
        Rst_n = 1'b1;
        Pnl_Req = 2'b11;
        step();
        check("post_rst_grant", 8'(Pnl_Grant), 8'd1);
        Pnl_Req = 2'b00;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_session_arbiter.md
# vend_session_arbiter

Shares one `VendingMachine` core between two customer panels. The block grants exclusive sessions by round-robin and clears the core before and after each session. During a session it forwards only the owner's coin and selection pulses and tracks inserted credit in half-TL units. It ends the session on dispense, on owner withdrawal or on inactivity timeout, and reports completion or a refund amount back to the owning panel.

## Interface
- `TIMEOUT_CYC`, default 255: idle cycles in SESSION before abort; meaningful only with `VEND_ARB_TIMEOUT_EN`.
- `Clk`  in  1  : single clock; all state changes on rising edge.
- `Rst_n`  in  1  : asynchronous, active-low reset.
- `Pnl_Req`  in  2  : level; panel i wants a session; owner must hold it for the whole session.
- `Pnl_OneTL`, `Pnl_HalfTL`, `Pnl_Coke`, `Pnl_Water`  in  2 each  : one-cycle pulses per panel.
- `Pnl_Grant`  out  2  : one-hot; panel owns the machine.
- `Pnl_Done`  out  2  : one-cycle pulse to the owner on dispense.
- `Pnl_Abort`  out  2  : one-cycle pulse to the owner on withdrawal or timeout.
- `Refund_Amt`  out  3  : credit in half-TL units; valid only while a `Pnl_Abort` bit is high; 0 otherwise.
- `Vm_Req`  out  1  : active-high clear pulse to the core.
- `Vm_OneTL`, `Vm_HalfTL`, `Vm_Coke`, `Vm_Water`  out  1 each  : forwarded owner pulses.
- `Vm_G_Coke`, `Vm_G_Water`, `Vm_Change1`, `Vm_Change05`  in  1 each  : core result levels.

## Operation
- States: IDLE, CLEAR, SESSION, DONE, ABORT. All outputs are registered.
- Reset:
  - State is IDLE and all outputs are 0.
  - Credit is 0 and the timer is 0.
  - The round-robin pointer `Last` is 1, so panel 0 wins the first tie.
- IDLE:
  - If any `Pnl_Req` bit is set, pick the owner: the requester other than `Last` if both request, otherwise the only requester.
  - Go to CLEAR.
- CLEAR, 1 cycle:
  - `Vm_Req`=1 and `Pnl_Grant[owner]`=1.
  - Credit and timer are set to 0.
  - Go to SESSION.
- SESSION:
  - The owner's pulses are forwarded to `Vm_*` registered, with 1-cycle delay. Non-owner pulses are dropped.
  - Credit arithmetic:
    - OneTL adds 2 and HalfTL adds 1.
    - If both arrive in the same cycle, only OneTL counts, matching the core's priority.
    - Credit saturates at 6.
  - Timer:
    - Cleared on any owner pulse.
    - Otherwise increments, saturating at `TIMEOUT_CYC`.
- SESSION exits, in priority order:
  1. `Vm_G_Coke` or `Vm_G_Water` high → DONE.
  2. `Pnl_Req[owner]` low → ABORT.
  3. Timer == `TIMEOUT_CYC` (macro enabled only) → ABORT.
- DONE, 1 cycle:
  - `Pnl_Done[owner]`=1 and `Vm_Req`=1.
  - `Last` = owner.
  - Go to IDLE.
- ABORT, 1 cycle:
  - `Pnl_Abort[owner]`=1, `Refund_Amt`=credit, `Vm_Req`=1.
  - `Last` = owner.
  - Go to IDLE.
- `Pnl_Grant[owner]` stays high from CLEAR through the DONE/ABORT cycle inclusive. It is 0 in IDLE.
- Change outputs (`Vm_Change*`) are not interpreted; the panel reads them directly off the core.

## Timing
- Request to grant: `Pnl_Req` sampled in IDLE gives `Pnl_Grant` and `Vm_Req` in the next cycle. Minimum 1 cycle.
- Panel pulse at cycle n appears on `Vm_*` at cycle n+1. Credit updates at cycle n+1.
- A dispense seen at cycle n gives `Pnl_Done` at cycle n+1. The next session's CLEAR is no earlier than n+3.
- Back-to-back: with both panels requesting continuously, grants alternate 0,1,0,1.
- The abort path runs the full session → ABORT → IDLE → CLEAR sequence; no session overlaps.
- A pulse arriving in the DONE or ABORT cycle is dropped. A pulse arriving in the CLEAR cycle is dropped.
- Reset asserted mid-session: immediate return to reset values, no `Vm_Req` pulse. The core is cleared by the next CLEAR.

## Configuration
- `VEND_ARB_TIMEOUT_EN` defined: the timer and its timeout abort are compiled in.
- Not defined: no timer logic; sessions end only by dispense or owner withdrawal, and `TIMEOUT_CYC` is ignored.

## Structure
- Package `vend_pkg`:
  - Contents: state enum, credit constants (`CREDIT_ONE`=2, `CREDIT_HALF`=1, `CREDIT_MAX`=6), panel count 2.
  - Timer width is derived from `TIMEOUT_CYC`.
- Sub-module `vend_rr_arbiter`: 2-way round-robin pick from `Pnl_Req` and `Last`, producing a one-hot grant. It is purely combinational.

## Test plan
- Reset, then assert `Pnl_Req`=2'b11 → `Pnl_Grant`=2'b01 with `Vm_Req`=1 one cycle later; after panel 0 finishes, the next grant is 2'b10.
- Panel 0: OneTL, HalfTL, Water → forwarded 1 cycle late. Core `G_Water`=1 → `Pnl_Done`=2'b01 next cycle, `Vm_Req`=1.
- Panel 0 inserts OneTL, OneTL, HalfTL, then drops `Pnl_Req` → `Pnl_Abort`=2'b01, `Refund_Amt`=5.
- Panel 1 pulses OneTL during panel 0's session → `Vm_OneTL` stays 0 and panel 0's credit is unchanged.
- Macro on, `TIMEOUT_CYC`=8: one HalfTL, then 8 idle cycles → `Pnl_Abort` pulses with `Refund_Amt`=1. Macro off: no abort after 1000 idle cycles.
- Four OneTL pulses → credit saturates at 6. `G_Coke` in the same cycle as `Pnl_Req` drops → DONE wins and `Pnl_Abort` stays 0.
